// File: rtl/pipe_mem_reader.sv
// pipe_mem_reader: two-stage load pipeline reading a word memory into a
// register bank. S1 holds the accepted request, S2 holds the loaded word
// presented on out_*. A completed hand-off on out_* writes the bank and
// bumps load_cnt. Memory contents survive reset; pipeline and bank do not.
module pipe_mem_reader #(
    parameter int AW = 8,
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [RW-1:0] req_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [RW-1:0] out_rd,
    input  logic [RW-1:0] rf_addr,
    output logic [DW-1:0] rf_data,
    output logic [7:0]    load_cnt
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] regbank [0:(1<<RW)-1];

    logic          s1_valid;
    logic [AW-1:0] s1_addr;
    logic [RW-1:0] s1_rd;

    logic          s2_valid;
    logic [DW-1:0] s2_data;
    logic [RW-1:0] s2_rd;

    logic stall;
    logic s1_advance;
    logic accept;
    logic deliver;
    logic forward_hit;

    // Handshake decode: S2 blocks when its word is not taken, S1 moves only into a free or draining S2
    always_comb begin
        stall       = s2_valid & ~out_ready;
        s1_advance  = s1_valid & ~stall;
        req_ready   = ~s1_valid | ~stall;
        accept      = req_valid & req_ready;
        deliver     = s2_valid & out_ready;
        forward_hit = wr_en && (wr_addr == s1_addr);
        out_valid   = s2_valid;
        out_data    = s2_data;
        out_rd      = s2_rd;
        rf_data     = regbank[rf_addr];
    end

    // Memory array has no reset so stored words outlive a pipeline reset
    always_ff @(posedge clk1) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Stage 1: capture accepted request, otherwise empty out once it has moved on
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_rd    <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_addr  <= req_addr;
            s1_rd    <= req_rd;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: read memory, taking a same-edge write to the same address in preference to the stale word
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_rd    <= '0;
        end else if (s1_advance) begin
            s2_valid <= 1'b1;
            s2_data  <= forward_hit ? wr_data : mem[s1_addr];
            s2_rd    <= s1_rd;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Register bank write-back and completed-load counter on each accepted result
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << RW); i++) begin
                regbank[i] <= '0;
            end
            load_cnt <= 8'd0;
        end else if (deliver) begin
            regbank[s2_rd] <= s2_data;
            load_cnt       <= load_cnt + 8'd1;
        end
    end

endmodule
